eth_phy_10g_rx_ber_mon: RTL
===========================

// Module: eth_phy_10g_rx_ber_mon
// PURPOSE
//  10GBASE-R receive BER monitor (IEEE 802.3 cl.49.2.13.2.12). Sits directly downstream of the RX block aligner.
//  Inspects each aligned sync header while block lock is held and counts invalid headers in fixed 125 us windows.
//  Asserts high-BER when BER_THRESH invalid headers land in one window, and keeps a saturating errored-header statistic.
// PARAMETERS
//  HDR_WIDTH    2      sync header width; valid header = 2'b01 or 2'b10 (hdr[1]^hdr[0])
//  COUNT_125US  19531  clk cycles per window (125 us at 156.25 MHz); sim benches override small
//  BER_THRESH   16     invalid headers per window that set high-BER
//  TOTAL_WIDTH  22     width of the errored-header statistic counter
// PORTS
//  clk               in   1            single clock, all logic on posedge
//  i_rst             in   1            synchronous reset, active-high
//  i_rx_block_lock   in   1            block lock from aligner
//  i_serdes_rx_hdr   in   HDR_WIDTH    aligned sync header from aligner
//  i_hdr_valid       in   1            header qualifier (tie 1 when a header arrives every clk)
//  i_clr_stats       in   1            single-cycle clear of o_err_total
//  o_rx_high_ber     out  1            high-BER status
//  o_ber_count       out  $clog2(BER_THRESH+1)  invalid headers in current window, saturates at BER_THRESH
//  o_err_total       out  TOTAL_WIDTH  invalid headers counted while locked, saturating
// BEHAVIOUR
//  - Reset: state=BER_INIT, o_rx_high_ber=0, o_ber_count=0, o_err_total=0, timer=0. All outputs registered.
//  - bad_sh = i_hdr_valid & i_rx_block_lock & ~(hdr[1]^hdr[0]). Cycles with i_hdr_valid=0 are ignored for counting.
//  - FSM (3 states):
//      BER_INIT: hi_ber=0, ber_count=0, timer=0. Go to WINDOW when i_rx_block_lock=1.
//      WINDOW:   timer += 1 each clk. ber_count += bad_sh (saturate at BER_THRESH).
//                hi_ber <= 1 in the cycle the incremented count reaches BER_THRESH, so the output rises 1 clk after that header.
//                Terminal cycle (timer==COUNT_125US-1): eff = ber_count+bad_sh.
//                hi_ber <= (eff>=BER_THRESH); next cycle timer=0, ber_count=0 (new window, no dead cycle).
//      Any state: i_rx_block_lock=0 -> next cycle BER_INIT (hi_ber=0, counts/timer cleared); o_err_total untouched.
//  - A bad header on the terminal cycle counts in the closing window only.
//  - While hi_ber=1, the window keeps running. It deasserts only at a window end whose eff < BER_THRESH.
//  - Timer width = $clog2(COUNT_125US); compare to COUNT_125US-1; wraps to 0, never overruns.
//  - o_err_total: +1 per bad_sh, saturates at all-ones. i_clr_stats has priority; clr with bad_sh in same clk -> 1.
//  - i_rst mid-window: next cycle identical to power-up reset, including o_err_total=0.
//  - Latency: bad header -> o_ber_count/o_err_total update 1 clk later.
// STRUCTURE
//  - Shared include eth_phy_10g_defs.vh: SYNC_DATA=2'b01, SYNC_CTRL=2'b10, default COUNT_125US, BER_THRESH.
//    The aligner uses the same sync header constants.
//  - FSM state localparams stay local.
//  - One natural sub-module: eth_sat_counter (param WIDTH; inc, clr, saturating), used for o_ber_count and o_err_total.
//  - Timer is inline.
// TESTING (COUNT_125US=100, BER_THRESH=16, TOTAL_WIDTH=4 unless stated)
//  1. Reset held 3 clk with random inputs -> all outputs 0; lock=1 after release -> window timer starts from 0.
//  2. lock=1, hdr alternating 2'b01/2'b10 for 3 windows -> o_rx_high_ber=0, o_ber_count=0, o_err_total=0.
//  3. 16 hdr=2'b00 in window 1 -> high_ber=1 one clk after 16th, held to window end;
//     clean window 2 -> drops the clk after window-2 terminal cycle.
//  4. 15 bad hdrs in a window, 16th on the next window's first cycle -> high_ber never asserts; o_ber_count 15 then 1.
//     Then 15 bad + 1 bad on the terminal cycle -> high_ber=1 after the terminal cycle.
//  5. high_ber=1, drop lock 1 clk -> high_ber=0 and o_ber_count=0 next clk; relock -> fresh 100-clk window.
//     Repeat with i_hdr_valid=0 on bad hdrs -> not counted.
//  6. 20 bad hdrs -> o_err_total saturates at 15; i_clr_stats with a bad hdr in the same clk -> o_err_total=1.

Source files
------------

// File: rtl/eth_phy_10g_rx_ber_mon_pkg.sv
// rtl/eth_phy_10g_rx_ber_mon_pkg.sv - shared 10GBASE-R sync header constants and defaults
package eth_phy_10g_rx_ber_mon_pkg;

  localparam int SYNC_HDR_WIDTH  = 2;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int COUNT_125US_DEF = 19531;
  localparam int BER_THRESH_DEF  = 16;
  localparam int TOTAL_WIDTH_DEF = 22;

  function automatic logic sync_hdr_ok(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// rtl/eth_sat_counter.sv - saturating up-counter with clear-over-increment priority
module eth_sat_counter #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX = '1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // A clear in the same cycle as an increment leaves the new event counted.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= WIDTH'(i_inc);
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// rtl/eth_phy_10g_rx_ber_mon.sv - 10GBASE-R RX BER monitor: windowed invalid sync header counting
module eth_phy_10g_rx_ber_mon
  import eth_phy_10g_rx_ber_mon_pkg::*;
#(
  parameter int HDR_WIDTH   = SYNC_HDR_WIDTH,
  parameter int COUNT_125US = COUNT_125US_DEF,
  parameter int BER_THRESH  = BER_THRESH_DEF,
  parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              i_rst,
  input  logic                              i_rx_block_lock,
  input  logic [HDR_WIDTH-1:0]              i_serdes_rx_hdr,
  input  logic                              i_hdr_valid,
  input  logic                              i_clr_stats,
  output logic                              o_rx_high_ber,
  output logic [$clog2(BER_THRESH+1)-1:0]   o_ber_count,
  output logic [TOTAL_WIDTH-1:0]            o_err_total
);

  localparam int TIMER_W = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
  localparam int CNT_W   = $clog2(BER_THRESH + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(COUNT_125US - 1);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_WINDOW = 2'd1;
  localparam logic [1:0] ST_HI_BER = 2'd2;

  logic [1:0]         r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_hi_ber;

  logic               w_bad_sh;
  logic               w_in_window;
  logic               w_terminal;
  logic               w_eff_hit;
  logic               w_ber_clr;
  logic               w_ber_inc;
  logic [CNT_W-1:0]   w_ber_count;

  assign w_bad_sh    = i_hdr_valid & i_rx_block_lock & ~sync_hdr_ok(i_serdes_rx_hdr);
  assign w_in_window = (r_state == ST_WINDOW) || (r_state == ST_HI_BER);
  assign w_terminal  = w_in_window && (r_timer == TIMER_LAST);
  assign w_eff_hit   = ({1'b0, w_ber_count} + {{CNT_W{1'b0}}, w_bad_sh}) >= (CNT_W+1)'(BER_THRESH);

  // A bad header on the terminal cycle belongs to the closing window, so the
  // window counter clears to 0 there instead of restarting at 1.
  assign w_ber_clr = ~w_in_window | ~i_rx_block_lock | w_terminal;
  assign w_ber_inc = w_bad_sh & ~w_ber_clr;

  always_ff @(posedge clk) begin
    if (i_rst || !i_rx_block_lock) begin
      r_state  <= ST_INIT;
      r_timer  <= '0;
      r_hi_ber <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state  <= ST_WINDOW;
          r_timer  <= '0;
          r_hi_ber <= 1'b0;
        end
        ST_WINDOW, ST_HI_BER: begin
          r_timer <= w_terminal ? '0 : r_timer + TIMER_W'(1);
          if (w_eff_hit) begin
            r_state  <= ST_HI_BER;
            r_hi_ber <= 1'b1;
          end else if (w_terminal) begin
            r_state  <= ST_WINDOW;
            r_hi_ber <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_INIT;
          r_timer  <= '0;
          r_hi_ber <= 1'b0;
        end
      endcase
    end
  end

  eth_sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (CNT_W'(BER_THRESH))
  ) u_ber_cnt (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clr   (w_ber_clr),
    .i_inc   (w_ber_inc),
    .o_count (w_ber_count)
  );

  eth_sat_counter #(
    .WIDTH (TOTAL_WIDTH)
  ) u_err_total (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clr   (i_clr_stats),
    .i_inc   (w_bad_sh),
    .o_count (o_err_total)
  );

  assign o_rx_high_ber = r_hi_ber;
  assign o_ber_count   = w_ber_count;

endmodule
